progmem_boot_ctrl: RTL and testbench

Controller that owns the program memory's single port and sequences it between a UART boot loader and the CPU fetch path. After reset it optionally receives a length-prefixed program image byte by byte from the UART receiver and writes it into program memory from address 0. It then releases the CPU and serves instruction fetches. The block sits between the UART RX, the CPU fetch stage and the program memory.

---
 rtl/progmem_boot_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_progmem_boot_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// progmem_boot_ctrl
//
// Owns the single port of the program memory. After reset it can receive a
// length-prefixed program image over the UART receiver and write it into
// program memory from address 0. It then releases the CPU and forwards
// instruction fetches to the memory.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   boot_en       1 = run the loader after reset, 0 = boot straight to RUN
//   rx_data/valid received UART byte and its one-cycle strobe
//   fetch_req     CPU fetch request (honoured only in RUN)
//   fetch_addr    CPU byte address
//   fetch_rdata   instruction word (memory read data)
//   fetch_valid   fetch_rdata valid, one cycle after fetch_req
//   mem_we/addr/din   program memory write port (registered)
//   mem_dout      program memory read data (registered by the memory)
//   cpu_hold      holds the CPU in reset while high
//   boot_done     image loaded or boot skipped, sticky until rst
//   boot_err      bad length or mid-load timeout, sticky until rst
// ---------------------------------------------------------------------------
module progmem_boot_ctrl #(
    parameter int MEM_SIZE     = 32767,
    parameter int BOOT_TIMEOUT = 1000000,
    localparam int ADDRW       = $clog2(MEM_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boot_en,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             fetch_req,
    input  logic [ADDRW-1:0] fetch_addr,
    output logic [31:0]      fetch_rdata,
    output logic             fetch_valid,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout,
    output logic             cpu_hold,
    output logic             boot_done,
    output logic             boot_err
);

    localparam int TW = (BOOT_TIMEOUT > 2) ? $clog2(BOOT_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST  = TW'(BOOT_TIMEOUT - 1);
    localparam logic [31:0]   LEN_MAX = 32'(MEM_SIZE + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [31:0]      len_q, len_d;
    logic [ADDRW:0]   wcnt_q, wcnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]      mem_din_q, mem_din_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             boot_done_q, boot_done_d;
    logic             boot_err_q, boot_err_d;

    logic [31:0]      len_full_s;
    logic             t_expired_s;

    // Next-state, counters and registered memory/fetch controls
    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        len_d         = len_q;
        wcnt_d        = wcnt_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        fetch_valid_d = 1'b0;
        // Length as it will be once the byte currently on rx_data is the MSB
        len_full_s    = {rx_data, len_q[23:0]};
        t_expired_s   = (tcnt_q == T_LAST);

        case (state_q)
            ST_IDLE: begin
                if (boot_en) begin
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LEN: begin
                // A byte arriving on the terminal count wins over the timeout
                if (rx_valid) begin
                    len_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (len_full_s == 32'd0) begin
                            state_d = ST_RUN;
                        end else if (len_full_s > LEN_MAX) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_LOAD;
                            wcnt_d  = '0;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end else if (t_expired_s) begin
                    // No byte at all means no host: keep the existing image
                    if (bcnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_LOAD: begin
                // Leaving one cycle after the last write lets it complete
                // before mem_addr switches to the fetch address
                if (32'(wcnt_q) == len_q) begin
                    state_d = ST_RUN;
                end else if (rx_valid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = wcnt_q[ADDRW-1:0];
                    mem_din_d  = {24'h00_0000, rx_data};
                    wcnt_d     = wcnt_q + {{ADDRW{1'b0}}, 1'b1};
                end else if (t_expired_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                fetch_valid_d = fetch_req;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte timeout: cleared by any byte or state change, saturating
        if ((state_d != state_q) || rx_valid) begin
            tcnt_d = '0;
        end else if (((state_q == ST_LEN) || (state_q == ST_LOAD)) && !t_expired_s) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = tcnt_q;
        end

        cpu_hold_d  = (state_d != ST_RUN);
        boot_done_d = boot_done_q | (state_d == ST_RUN);
        boot_err_d  = boot_err_q | (state_d == ST_ERR);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bcnt_q        <= 2'd0;
            len_q         <= 32'd0;
            wcnt_q        <= '0;
            tcnt_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= 32'd0;
            fetch_valid_q <= 1'b0;
            cpu_hold_q    <= 1'b1;
            boot_done_q   <= 1'b0;
            boot_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            len_q         <= len_d;
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            fetch_valid_q <= fetch_valid_d;
            cpu_hold_q    <= cpu_hold_d;
            boot_done_q   <= boot_done_d;
            boot_err_q    <= boot_err_d;
        end
    end

    // In RUN the fetch address goes straight to the memory so the word is
    // available one cycle after the request
    assign mem_addr    = (state_q == ST_RUN) ? fetch_addr : mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_din     = mem_din_q;
    assign fetch_rdata = mem_dout;
    assign fetch_valid = fetch_valid_q;
    assign cpu_hold    = cpu_hold_q;
    assign boot_done   = boot_done_q;
    assign boot_err    = boot_err_q;

endmodule

// File: tb/tb_progmem_boot_ctrl.sv
module tb_progmem_boot_ctrl;

    localparam int MEM_SIZE     = 32767;
    localparam int BOOT_TIMEOUT = 16;
    localparam int ADDRW        = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             boot_en = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             fetch_req = 1'b0;
    logic [ADDRW-1:0] fetch_addr = '0;
    logic [31:0]      fetch_rdata;
    logic             fetch_valid;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [31:0]      mem_din;
    logic [31:0]      mem_dout = 32'h0;
    logic             cpu_hold;
    logic             boot_done;
    logic             boot_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_start = 1;

    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [7:0]       data;
        int               cyc;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] fetch_q[$];
    logic [7:0]  mem [0:MEM_SIZE];

    progmem_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .BOOT_TIMEOUT(BOOT_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .boot_en(boot_en),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .cpu_hold(cpu_hold),
        .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(input logic [ADDRW-1:0] a);
        return {mem[a + 15'd3], mem[a + 15'd2], mem[a + 15'd1], mem[a]};
    endfunction

    // Program memory model: registered read on posedge, write on negedge
    always @(posedge clk) mem_dout <= word_at(mem_addr);
    always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_din[7:0];

    // Scoreboard monitors sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d din=%h at cyc %0d, no write expected", mem_addr, mem_din, cyc);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if (mem_addr !== e.addr || mem_din !== {24'h0, e.data} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: addr=%0d din=%h cyc=%0d, expected addr=%0d din=%h cyc=%0d",
                             mem_addr, mem_din, cyc, e.addr, {24'h0, e.data}, e.cyc);
                end
            end
        end
        if (!rst && fetch_valid) begin
            checks++;
            if (fetch_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fetch_valid: rdata=%h at cyc %0d", fetch_rdata, cyc);
            end else begin
                logic [31:0] w;
                w = fetch_q.pop_front();
                if (fetch_rdata !== w) begin
                    errors++;
                    $display("FAIL fetch_rdata: got %h, expected %h", fetch_rdata, w);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit wr, input logic [ADDRW-1:0] a);
        wr_t e;
        rx_data  = b;
        rx_valid = 1'b1;
        if (wr) begin
            e.addr = a; e.data = b; e.cyc = cyc + 1;
            wr_q.push_back(e);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], 1'b0, '0);
    endtask

    task automatic reset_dut(input logic be);
        rst = 1'b1; boot_en = be; rx_valid = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_boot();
        reset_dut(1'b1);
        repeat (n_start) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || boot_done !== 1'b0 || boot_err !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== '0 || mem_din !== 32'h0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: hold=%b done=%b err=%b we=%b addr=%0d din=%h fv=%b, expected 1 0 0 0 0 0 0",
                     cpu_hold, boot_done, boot_err, mem_we, mem_addr, mem_din, fetch_valid);
        end
    endtask

    task automatic test_no_boot();
        int n;
        reset_dut(1'b0);
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++; $display("FAIL noboot_hold_at_release: got %b, expected 1", cpu_hold);
        end
        n = 0;
        while (cpu_hold === 1'b1 && n < 5) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n < 1 || n > 2) begin
            errors++; $display("FAIL noboot_hold_fall: %0d cycles, expected 1..2", n);
        end else begin
            n_start = n;
        end
        checks++;
        if (boot_done !== 1'b1 || boot_err !== 1'b0) begin
            errors++; $display("FAIL noboot_flags: done=%b err=%b, expected 1 0", boot_done, boot_err);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        start_boot();
        send_len(32'd3);
        send_byte(8'hAA, 1'b1, 15'd0);
        send_byte(8'hBB, 1'b1, 15'd1);
        send_byte(8'hCC, 1'b1, 15'd2);
        checks++;
        if (cpu_hold !== 1'b1 || boot_done !== 1'b0) begin
            errors++; $display("FAIL load_hold_during_last_write: hold=%b done=%b, expected 1 0", cpu_hold, boot_done);
        end
        @(posedge clk); #1;
        checks++;
        if (cpu_hold !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0) begin
            errors++; $display("FAIL load_run: hold=%b done=%b err=%b, expected 0 1 0", cpu_hold, boot_done, boot_err);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++; $display("FAIL load_writes_pending: %0d left, expected 0", wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_fetch();
        fetch_req = 1'b1; fetch_addr = 15'd0; fetch_q.push_back(32'h00CCBBAA);
        @(posedge clk); #1;
        fetch_addr = 15'd4; fetch_q.push_back(32'h0000_0000);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fetch_q.size() != 0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_back_to_back: %0d pending, fv=%b, expected 0 0", fetch_q.size(), fetch_valid);
            fetch_q.delete();
        end
    endtask

    task automatic test_len_boundary();
        start_boot();
        send_len(32'h0000_8000);
        send_byte(8'h5A, 1'b1, 15'd0);
        @(posedge clk); #1;
        checks++;
        if (wr_q.size() != 0 || boot_err !== 1'b0 || cpu_hold !== 1'b1 || boot_done !== 1'b0) begin
            errors++; $display("FAIL len_max_accepted: pending=%0d err=%b hold=%b done=%b, expected 0 0 1 0",
                               wr_q.size(), boot_err, cpu_hold, boot_done);
            wr_q.delete();
        end
        start_boot();
        send_len(32'h0000_8001);
        checks++;
        if (boot_err !== 1'b1 || cpu_hold !== 1'b1 || boot_done !== 1'b0) begin
            errors++; $display("FAIL len_too_big: err=%b hold=%b done=%b, expected 1 1 0", boot_err, cpu_hold, boot_done);
        end
        fetch_req = 1'b1;
        send_byte(8'h11, 1'b0, '0);
        repeat (20) @(posedge clk);
        #1 fetch_req = 1'b0;
        checks++;
        if (boot_err !== 1'b1 || cpu_hold !== 1'b1 || boot_done !== 1'b0) begin
            errors++; $display("FAIL err_terminal: err=%b hold=%b done=%b, expected 1 1 0", boot_err, cpu_hold, boot_done);
        end
    endtask

    task automatic test_timeout();
        int n;
        reset_dut(1'b1);
        n = 0;
        while (cpu_hold === 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != n_start + BOOT_TIMEOUT) begin
            errors++; $display("FAIL timeout_no_host: %0d cycles, expected %0d", n, n_start + BOOT_TIMEOUT);
        end
        checks++;
        if (boot_err !== 1'b0 || boot_done !== 1'b1) begin
            errors++; $display("FAIL timeout_no_host_flags: err=%b done=%b, expected 0 1", boot_err, boot_done);
        end
        start_boot();
        send_len(32'd4);
        send_byte(8'h01, 1'b1, 15'd0);
        send_byte(8'h02, 1'b1, 15'd1);
        repeat (BOOT_TIMEOUT - 1) @(posedge clk);
        #1;
        checks++;
        if (boot_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: err=%b, expected 0", boot_err);
        end
        @(posedge clk); #1;
        checks++;
        if (boot_err !== 1'b1 || cpu_hold !== 1'b1 || boot_done !== 1'b0 || wr_q.size() != 0) begin
            errors++; $display("FAIL timeout_load: err=%b hold=%b done=%b pending=%0d, expected 1 1 0 0",
                               boot_err, cpu_hold, boot_done, wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_byte_wins();
        start_boot();
        repeat (BOOT_TIMEOUT - 1) @(posedge clk);
        #1;
        send_len(32'd1);
        send_byte(8'h3C, 1'b1, 15'd0);
        @(posedge clk); #1;
        checks++;
        if (cpu_hold !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0 || wr_q.size() != 0) begin
            errors++; $display("FAIL byte_wins_timeout: hold=%b done=%b err=%b pending=%0d, expected 0 1 0 0",
                               cpu_hold, boot_done, boot_err, wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_rst_mid_load();
        start_boot();
        send_len(32'd5);
        send_byte(8'h11, 1'b1, 15'd0);
        send_byte(8'h22, 1'b1, 15'd1);
        send_byte(8'h33, 1'b0, '0);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_din !== 32'h0 || cpu_hold !== 1'b1 ||
            boot_done !== 1'b0 || boot_err !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: we=%b addr=%0d din=%h hold=%b done=%b err=%b fv=%b, expected 0 0 0 1 0 0 0",
                               mem_we, mem_addr, mem_din, cpu_hold, boot_done, boot_err, fetch_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[2] !== 8'hCC || mem[1] !== 8'h22) begin
            errors++; $display("FAIL partial_write: mem[1]=%h mem[2]=%h, expected 22 CC", mem[1], mem[2]);
        end
        start_boot();
        send_len(32'd1);
        send_byte(8'h77, 1'b1, 15'd0);
        @(posedge clk); #1;
        checks++;
        if (cpu_hold !== 1'b0 || boot_done !== 1'b1 || wr_q.size() != 0 || mem[0] !== 8'h77) begin
            errors++; $display("FAIL reboot_len1: hold=%b done=%b pending=%0d mem0=%h, expected 0 1 0 77",
                               cpu_hold, boot_done, wr_q.size(), mem[0]);
            wr_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= MEM_SIZE; i++) mem[i] = 8'h00;
        test_reset();
        test_no_boot();
        test_load();
        test_fetch();
        test_len_boundary();
        test_timeout();
        test_byte_wins();
        test_rst_mid_load();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || fetch_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: writes=%0d fetches=%0d, expected 0 0", wr_q.size(), fetch_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
